// File: rtl/fetch_hazard_ctrl_if.sv
// ============================================================================
// Module      : fetch_hazard_ctrl_if
// Description : Hazard inputs and fetch-control outputs of the fetch hazard
//               controller. stall_cnt exists only when STALL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_hazard_ctrl_if;
  logic       ld_use_hz;
  logic       md_use_D;
  logic       md_start;
  logic       md_is_div;
  logic       jump_D;
  logic       jr_D;
  logic       br_taken_D;
  logic [1:0] NPCOp;
  logic       enPC;
  logic       enD;
  logic       clrE;
  logic       stall;
  logic       md_busy;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  // master: the controller; slave: the pipeline datapath it steers
  modport master (
`ifdef STALL_PERF_EN
    output stall_cnt,
`endif
    input  ld_use_hz, md_use_D, md_start, md_is_div, jump_D, jr_D, br_taken_D,
    output NPCOp, enPC, enD, clrE, stall, md_busy
  );

  modport slave (
`ifdef STALL_PERF_EN
    input  stall_cnt,
`endif
    output ld_use_hz, md_use_D, md_start, md_is_div, jump_D, jr_D, br_taken_D,
    input  NPCOp, enPC, enD, clrE, stall, md_busy
  );
endinterface

`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Fetch-stage sequencer for a 5-stage MIPS pipeline: load-use and
//               mult/div stalls, jump/branch/jr redirect, mult/div latency count.
//               Optional macro STALL_PERF_EN adds a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_hazard_ctrl_if.master  bus
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] NPC_ADD4  = 2'b00;
  localparam logic [1:0] NPC_JUMP  = 2'b01;
  localparam logic [1:0] NPC_RD1   = 2'b10;
  localparam logic [1:0] NPC_RESET = 2'b11;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       run;
  logic       busy;
  logic       stall_run;

  assign run       = (state_q == RUN);
  assign busy      = (md_cnt_q != 4'd0);
  // md_start bypass: the consumer stalls in the same cycle the op enters E
  assign stall_run = bus.ld_use_hz | (bus.md_use_D & (busy | bus.md_start));

  always_comb begin
    bus.NPCOp   = NPC_RESET;
    bus.enPC    = 1'b1;
    bus.enD     = 1'b0;
    bus.clrE    = 1'b1;
    bus.stall   = 1'b0;
    bus.md_busy = 1'b0;
    if (run) begin
      bus.stall   = stall_run;
      bus.md_busy = busy;
      if (stall_run) begin
        // redirect held off: D-stage operands are stale until the stall drops
        bus.NPCOp = NPC_ADD4;
        bus.enPC  = 1'b0;
        bus.enD   = 1'b0;
        bus.clrE  = 1'b1;
      end else begin
        bus.enPC = 1'b1;
        bus.enD  = 1'b1;
        bus.clrE = 1'b0;
        if (bus.jr_D) begin
          bus.NPCOp = NPC_RD1;
        end else if (bus.jump_D | bus.br_taken_D) begin
          bus.NPCOp = NPC_JUMP;
        end else begin
          bus.NPCOp = NPC_ADD4;
        end
      end
    end
  end

  always_comb begin
    state_d  = RUN;
    md_cnt_d = 4'd0;
    if (run) begin
      if (busy) begin
        md_cnt_d = md_cnt_q - 4'd1;
      end else if (bus.md_start) begin
        md_cnt_d = bus.md_is_div ? DIV_LOAD : MULT_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (run && stall_run && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Sequencing controller for the fetch stage of the 5-stage MIPS pipeline. It drives the fetch stage's next-PC select and PC enable, the IF/ID register enable and the ID/EX bubble clear. It resolves load-use stalls and mult/div busy stalls, and selects the jump/branch/jr redirect with a delay slot. It owns the mult/div latency counter, so the MD unit needs no handshake back.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu starts in E.
DIV_CYCLES, 10, busy cycles after a div/divu starts in E; max 15, fits the 4-bit counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
ld_use_hz  input  1  D-stage instr reads a reg written by the E-stage load
md_use_D  input  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
md_start  input  1  E-stage instr is mult/div (any signedness) this cycle
md_is_div  input  1  qualifies md_start: 1=div, 0=mult
jump_D  input  1  D-stage instr is j/jal
jr_D  input  1  D-stage instr is jr/jalr
br_taken_D  input  1  D-stage branch evaluated taken
NPCOp  output  2  00 ADD4, 01 PCJump, 10 RD1, 11 reset vector 0x0000_3000
enPC  output  1  PC register write enable
enD  output  1  IF/ID register write enable
clrE  output  1  ID/EX synchronous clear (bubble)
stall  output  1  pipeline stalled this cycle
md_busy  output  1  mult/div counter nonzero

Behaviour:
- FSM states: BOOT and RUN. The 4-bit register md_cnt is the only other state.
- Reset: synchronous. At any clk edge with reset=1: state<=BOOT, md_cnt<=0.
- BOOT outputs: NPCOp=11, enPC=1, enD=0, clrE=1, stall=0, md_busy=0.
- BOOT lasts from the first edge with reset=1 through the first edge with reset=0, then goes to RUN. The PC is therefore reloaded with 0x3000 and the pipeline receives one bubble.
- RUN stall condition (combinational): stall = ld_use_hz | (md_use_D & (md_busy | md_start)).
- RUN with stall=1: enPC=0, enD=0, clrE=1, NPCOp=00. Redirect is suppressed because D-stage operands are stale. The redirect is re-evaluated on the cycle stall drops.
- RUN with stall=0: enPC=1, enD=1, clrE=0.
- RUN NPCOp priority when stall=0: jr_D -> 10; else (jump_D | br_taken_D) -> 01; else 00.
- Delay slot: the F instruction is never flushed on redirect.
- jr_D together with jump_D is illegal but defined: jr wins.
- md_cnt update in RUN, each edge:
  - md_cnt==0 and md_start: load DIV_CYCLES if md_is_div, else MULT_CYCLES.
  - md_cnt!=0: decrement; md_start is ignored (cannot occur legally; the counter is not reloaded).
  - otherwise hold at 0.
- md_busy = (md_cnt!=0). It asserts the cycle after md_start and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- In BOOT, md_start is ignored. A reset mid-operation clears md_cnt immediately at that edge.
- All outputs are combinational from state, md_cnt and inputs. No input-to-state path bypasses reset.

Optional Feature:
Macro STALL_PERF_EN.
- Defined: adds output stall_cnt [31:0], a saturating count of RUN cycles with stall=1. It is cleared by reset, holds at 0xFFFF_FFFF on saturation, and BOOT cycles are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0 -> NPCOp=11, enPC=1, enD=0, clrE=1 through the first low edge; next cycle NPCOp=00, enPC=enD=1, clrE=0.
- Load-use: ld_use_hz=1 for 1 cycle with jump_D=1 -> that cycle stall=1, enPC=enD=0, clrE=1, NPCOp=00; next cycle (ld_use_hz=0, jump_D=1) -> NPCOp=01, enPC=1.
- Redirect priority, no stall: jr_D=1 with br_taken_D=1 -> NPCOp=10; br_taken_D=1 alone -> 01; nothing asserted -> 00; clrE=0 throughout.
- Divide stall: md_start=1, md_is_div=1 at cycle t, md_use_D=1 held from t -> stall=1 at t (start bypass); md_busy=1 for cycles t+1..t+10; stall deasserts at t+11.
- Mult, no consumer: md_start=1, md_is_div=0, md_use_D=0 -> md_busy high exactly 5 cycles, stall stays 0; a second md_start during busy does not extend busy.
- Reset mid-divide: assert reset 3 cycles after a div start -> md_busy=0 and BOOT outputs from that edge; after release, md_use_D=1 causes no stall.
